// File: rtl/mux_rr_arbiter_2to1_if.sv
// Handshake bundle for mux_rr_arbiter_2to1.
//   a_valid/a_data/a_ready : requester a (valid/ready)
//   b_valid/b_data/b_ready : requester b (valid/ready)
//   y_valid/y_data/y_src/y_ready : output register handshake, y_src 0=a 1=b
// master : requester/downstream side (drives valids, data, y_ready)
// slave  : arbiter side (drives readies and y_*)
interface mux_rr_arbiter_2to1_if #(
   parameter int WIDTH = 4
);
   logic             a_valid;
   logic [WIDTH-1:0] a_data;
   logic             a_ready;
   logic             b_valid;
   logic [WIDTH-1:0] b_data;
   logic             b_ready;
   logic             y_valid;
   logic [WIDTH-1:0] y_data;
   logic             y_src;
   logic             y_ready;

   modport master (
      output a_valid, a_data, b_valid, b_data, y_ready,
      input  a_ready, b_ready, y_valid, y_data, y_src
   );

   modport slave (
      input  a_valid, a_data, b_valid, b_data, y_ready,
      output a_ready, b_ready, y_valid, y_data, y_src
   );
endinterface

// File: rtl/mux_rr_arbiter_2to1.sv
// Round-robin 2:1 arbiter feeding a one-entry output register.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : mux_rr_arbiter_2to1_if.slave -- requester a/b handshakes and the
//         y output handshake (y_src 0 = a, 1 = b)
//
// state | meaning
// EMPTY | output register holds no word
// FULL  | output register holds a word (y_valid = 1)
module mux_rr_arbiter_2to1 #(
   parameter int WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   mux_rr_arbiter_2to1_if.slave  bus
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t           state_q, state_d;
   logic             last_q, last_d;      // last served id: 0 = a, 1 = b
   logic [WIDTH-1:0] y_data_q, y_data_d;
   logic             y_src_q, y_src_d;
   logic             load;
   logic             grant_a, grant_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= EMPTY;
         last_q   <= 1'b1;
         y_data_q <= '0;
         y_src_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         y_data_q <= y_data_d;
         y_src_q  <= y_src_d;
      end
   end

   always_comb begin
      grant_a  = 1'b0;
      grant_b  = 1'b0;
      state_d  = state_q;
      last_d   = last_q;
      y_data_d = y_data_q;
      y_src_d  = y_src_q;

      // The register can take a word when empty or when its word leaves now.
      load = (state_q == EMPTY) | ((state_q == FULL) & bus.y_ready);

      // Readies are gated by rst so nothing is accepted during reset.
      if (!rst && load) begin
         if (bus.a_valid && (!bus.b_valid || last_q))
            grant_a = 1'b1;
         else if (bus.b_valid)
            grant_b = 1'b1;
      end

      if (grant_a) begin
         state_d  = FULL;
         y_data_d = bus.a_data;
         y_src_d  = 1'b0;
         last_d   = 1'b0;
      end else if (grant_b) begin
         state_d  = FULL;
         y_data_d = bus.b_data;
         y_src_d  = 1'b1;
         last_d   = 1'b1;
      end else if (load) begin
         // Drained (or stayed empty) with no replacement; data/src hold.
         state_d = EMPTY;
      end
   end

   assign bus.a_ready = grant_a;
   assign bus.b_ready = grant_b;
   assign bus.y_valid = (state_q == FULL);
   assign bus.y_data  = y_data_q;
   assign bus.y_src   = y_src_q;

endmodule

// File: tb/tb_mux_rr_arbiter_2to1.sv
module tb_mux_rr_arbiter_2to1;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   mux_rr_arbiter_2to1_if #(.WIDTH(4)) bus ();

   mux_rr_arbiter_2to1 #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected output words in delivery order: {src, data}.
   logic [4:0] exp_q[$];
   logic       ref_last;   // last served id, 1 after reset so a goes first
   logic       after_rst;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // One clock cycle: drive inputs just after the edge, then late in the cycle
   // compare the readies against the reference arbitration and record grants.
   // The output register is free exactly when no undelivered word remains.
   task automatic cycle(input logic r, input logic av, input logic [3:0] ad,
                        input logic bv, input logic [3:0] bd, input logic yr,
                        output int gid);
      logic ea, eb;
      @(posedge clk);
      #1;
      rst = r;
      bus.a_valid = av; bus.a_data = ad;
      bus.b_valid = bv; bus.b_data = bd;
      bus.y_ready = yr;
      #7;
      ea = 1'b0; eb = 1'b0; gid = -1;
      if (!r && exp_q.size() == 0) begin
         if (av && bv) begin
            if (ref_last == 1'b1) ea = 1'b1; else eb = 1'b1;
         end else if (av) ea = 1'b1;
         else if (bv) eb = 1'b1;
      end
      check("a_ready", int'(bus.a_ready), int'(ea));
      check("b_ready", int'(bus.b_ready), int'(eb));
      if (r) begin
         exp_q.delete();
         ref_last = 1'b1;
      end else if (ea) begin
         exp_q.push_back({1'b0, ad});
         ref_last = 1'b0;
         gid = 0;
      end else if (eb) begin
         exp_q.push_back({1'b1, bd});
         ref_last = 1'b1;
         gid = 1;
      end
   endtask

   // Output monitor: the register must present the oldest undelivered word
   // every cycle and retire it on a y handshake.
   always @(negedge clk) begin
      if (rst) begin
         after_rst = 1'b1;
      end else begin
         if (after_rst) begin
            check("rst_y_valid", int'(bus.y_valid), 0);
            check("rst_y_data", int'(bus.y_data), 0);
            check("rst_y_src", int'(bus.y_src), 0);
            after_rst = 1'b0;
         end
         check("y_valid", int'(bus.y_valid), int'(exp_q.size() != 0));
         if (bus.y_valid && exp_q.size() != 0) begin
            check("y_data", int'(bus.y_data), int'(exp_q[0][3:0]));
            check("y_src", int'(bus.y_src), int'(exp_q[0][4]));
            if (bus.y_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      int         g;
      logic       av, bv, yr, r;
      logic [3:0] ad, bd;
      int         exp_seq[4];

      n_pass = 0; n_total = 0;
      ref_last = 1'b1; after_rst = 1'b0;
      rst = 1'b1;
      bus.a_valid = 1'b0; bus.a_data = '0;
      bus.b_valid = 1'b0; bus.b_data = '0;
      bus.y_ready = 1'b0;

      // Reset held with both requesters valid.
      cycle(1, 1, 4'h3, 1, 4'hC, 1, g);
      cycle(1, 1, 4'h3, 1, 4'hC, 1, g);

      // Single requester.
      cycle(0, 1, 4'b1010, 0, 4'h0, 1, g);
      check("single_grant_a", g, 0);
      cycle(0, 0, 4'h0, 0, 4'h0, 1, g);

      // Contention from reset: a, b, a, b.
      cycle(1, 0, 4'h0, 0, 4'h0, 1, g);
      exp_seq = '{0, 1, 0, 1};
      for (int i = 0; i < 4; i++) begin
         cycle(0, 1, 4'b0000, 1, 4'b1111, 1, g);
         check("contention_seq", g, exp_seq[i]);
      end
      cycle(0, 0, 4'h0, 0, 4'h0, 1, g);

      // Backpressure: b word held while y_ready=0, a waits.
      cycle(0, 0, 4'h0, 1, 4'b0101, 1, g);
      check("bp_load_b", g, 1);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1, 4'b0110, 0, 4'h0, 0, g);
         check("bp_no_grant", g, -1);
      end
      cycle(0, 1, 4'b0110, 0, 4'h0, 1, g);
      check("bp_release_a", g, 0);
      cycle(0, 0, 4'h0, 0, 4'h0, 1, g);

      // Priority survives idle cycles.
      cycle(0, 0, 4'h0, 1, 4'b1001, 1, g);
      check("idle_grant_b", g, 1);
      cycle(0, 0, 4'h0, 0, 4'h0, 1, g);
      cycle(0, 0, 4'h0, 0, 4'h0, 1, g);
      cycle(0, 1, 4'b0011, 1, 4'b1100, 1, g);
      check("idle_then_a", g, 0);
      cycle(0, 0, 4'h0, 1, 4'b1100, 1, g);
      check("idle_then_b", g, 1);

      // Reset mid-operation with a full register.
      cycle(0, 0, 4'h0, 0, 4'h0, 1, g);
      cycle(0, 1, 4'b1111, 0, 4'h0, 0, g);
      check("midrst_load", g, 0);
      cycle(0, 0, 4'h0, 0, 4'h0, 0, g);
      cycle(1, 1, 4'h5, 1, 4'hA, 0, g);
      cycle(0, 1, 4'h5, 1, 4'hA, 1, g);
      check("midrst_a_first", g, 0);

      // Randomized traffic; ungranted requests mostly stay stable.
      av = 1'b0; bv = 1'b0; ad = '0; bd = '0;
      for (int i = 0; i < 800; i++) begin
         r  = ($urandom_range(0, 99) == 0);
         yr = ($urandom_range(0, 3) != 0);
         cycle(r, av, ad, bv, bd, yr, g);
         if (!(av && g != 0) || $urandom_range(0, 7) == 0) begin
            av = $urandom_range(0, 1) == 1;
            ad = 4'($urandom_range(0, 15));
         end
         if (!(bv && g != 1) || $urandom_range(0, 7) == 0) begin
            bv = $urandom_range(0, 1) == 1;
            bd = 4'($urandom_range(0, 15));
         end
      end

      // Drain whatever is left.
      for (int i = 0; i < 3; i++) cycle(0, 0, 4'h0, 0, 4'h0, 1, g);
      check("final_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
